// File: rtl/reg_pkg.sv
// Shared types and sizing helpers for the reg_pipe skid-buffer pipeline.
package reg_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Occupancy counter width: must represent 0 .. 2*depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/reg_skid.sv
// Single skid-buffer stage: main + skid register, ready taken straight from a flop so
// downstream ready never reaches upstream combinationally.
module reg_skid
  import reg_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  RSTN_VALUE = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data
);

  skid_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  ready_q;
  logic                  in_fire;
  logic                  out_fire;

  assign o_ready  = ready_q;
  assign o_valid  = (state_q != EMPTY);
  assign o_data   = main_q;
  assign in_fire  = i_valid & ready_q;
  assign out_fire = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush empties the stage but leaves data registers untouched.
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = i_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_d = i_data;
          end else if (in_fire) begin
            skid_d  = i_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      main_q  <= RSTN_VALUE;
      skid_q  <= RSTN_VALUE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != FULL);
    end
  end

endmodule

// File: rtl/reg_pipe.sv
// Chain of DEPTH skid stages with a pipe-wide occupancy counter and flush fan-out.
module reg_pipe
  import reg_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RSTN_VALUE = '0,
  parameter int                    DEPTH      = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_flush,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic [count_width(DEPTH)-1:0]   o_count
);

  localparam int CntW = count_width(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("reg_pipe: DEPTH must be at least 1");
  end

  // Index k is the handshake between stage k-1 and stage k; 0 is the pipe input.
  logic [DEPTH:0]                 valid_c;
  logic [DEPTH:0]                 ready_c;
  logic [DEPTH:0][DATA_WIDTH-1:0] data_c;

  assign valid_c[0]     = i_valid;
  assign data_c[0]      = i_data;
  assign ready_c[DEPTH] = i_ready;
  assign o_ready        = ready_c[0];
  assign o_valid        = valid_c[DEPTH];
  assign o_data         = data_c[DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    reg_skid #(
      .DATA_WIDTH (DATA_WIDTH),
      .RSTN_VALUE (RSTN_VALUE)
    ) u_skid (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_flush (i_flush),
      .i_valid (valid_c[k]),
      .o_ready (ready_c[k]),
      .i_data  (data_c[k]),
      .o_valid (valid_c[k+1]),
      .i_ready (ready_c[k+1]),
      .o_data  (data_c[k+1])
    );
  end

  logic            in_fire;
  logic            out_fire;
  logic [CntW-1:0] count_q, count_d;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;
  assign o_count  = count_q;

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = '0;
    end else if (in_fire && !out_fire) begin
      count_d = count_q + CntW'(1);
    end else if (out_fire && !in_fire) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// Directed and randomised checks of reg_pipe with DATA_WIDTH=8, DEPTH=2, RSTN_VALUE=8'hA5.
module tb_reg_pipe;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  int tests;
  int fails;

  reg_pipe #(
    .DATA_WIDTH (8),
    .RSTN_VALUE (8'hA5),
    .DEPTH      (2)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (out_ready),
    .i_data  (in_data),
    .o_valid (out_valid),
    .i_ready (in_ready),
    .o_data  (out_data),
    .o_count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    int         expw;
    int         idx;
    logic       acc;
    logic       seen;
    logic       in_f;
    logic       out_f;

    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_ready = 1'b0;
    in_data = 8'h00;

    // Reset takes effect without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 8'hA5);
    chk("rst_ready", out_ready, 1);
    chk("rst_count", count, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step();
    chk("post_rst_data", out_data, 8'hA5);
    chk("post_rst_ready", out_ready, 1);
    chk("post_rst_valid", out_valid, 0);

    // Streaming: words 1..10 at full rate, two-edge latency, count settles at 2.
    in_ready = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      in_valid = (e <= 10);
      in_data  = 8'(e);
      step();
      if (e >= 2 && e <= 11) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_data", out_data, 32'(e - 1));
      end else begin
        chk("stream_valid", out_valid, 0);
      end
      chk("stream_count", count, (e == 1) ? 1 : (e <= 10) ? 2 : (e == 11) ? 1 : 0);
      chk("stream_ready", out_ready, 1);
    end
    in_valid = 1'b0;

    // Backpressure: four words fill the pipe, the fifth waits upstream.
    in_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      in_valid = 1'b1;
      in_data  = 8'(w);
      step();
      chk("stall_count", count, 32'(w));
      chk("stall_ready", out_ready, (w < 4) ? 1 : 0);
    end
    in_data = 8'd5;
    repeat (2) begin
      step();
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_data", out_data, 1);
      chk("stall_hold_ready", out_ready, 0);
      chk("stall_hold_count", count, 4);
    end
    in_ready = 1'b1;
    expw = 1;
    for (int c = 0; c < 20 && expw <= 5; c++) begin
      acc = in_valid & out_ready;
      if (out_valid) begin
        chk("drain_data", out_data, 32'(expw));
        expw++;
      end
      step();
      if (acc) in_valid = 1'b0;
    end
    chk("drain_words", 32'(expw), 6);
    chk("drain_in_taken", in_valid, 0);
    repeat (2) step();
    chk("drain_count", count, 0);
    chk("drain_valid", out_valid, 0);

    // Flush with a simultaneous in-fire at count 3.
    in_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 * (w + 1));
      step();
    end
    chk("pre_flush_count", count, 3);
    chk("pre_flush_ready", out_ready, 1);
    in_data = 8'h77;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_count", count, 0);
    chk("flush_ready", out_ready, 1);
    in_ready = 1'b1;
    repeat (4) begin
      step();
      chk("flush_quiet", out_valid, 0);
    end
    in_valid = 1'b1;
    in_data = 8'h42;
    step();
    in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      if (out_valid) begin
        chk("post_flush_data", out_data, 8'h42);
        seen = 1'b1;
      end
      step();
    end
    chk("post_flush_seen", seen, 1);

    // Reset dropped between edges while words are in flight.
    in_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h60 + w);
      step();
    end
    chk("mid_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 8'hA5);
    chk("mid_rst_ready", out_ready, 1);
    chk("mid_rst_count", count, 0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expw = 8'h81;
    idx = 0;
    for (int c = 0; c < 30 && expw <= 8'h85; c++) begin
      in_valid = (idx < 5);
      in_data  = 8'(8'h81 + idx);
      acc = in_valid & out_ready;
      if (out_valid) begin
        chk("restart_data", out_data, 32'(expw));
        expw++;
      end
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("restart_words", 32'(expw), 8'h86);

    // Random traffic against a queue scoreboard.
    repeat (3) step();
    q.delete();
    for (int c = 0; c < 1000; c++) begin
      chk("rnd_count", count, 32'(q.size()));
      if (out_valid) begin
        chk("rnd_nonempty", (q.size() != 0), 1);
        if (q.size() != 0) chk("rnd_data", out_data, q[0]);
      end
      in_valid = ($urandom_range(0, 3) != 0);
      in_ready = ($urandom_range(0, 2) != 0);
      flush    = ($urandom_range(0, 63) == 0);
      in_data  = 8'($urandom);
      in_f  = in_valid & out_ready;
      out_f = out_valid & in_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(in_data);
      end
      step();
      if (flush) begin
        chk("rnd_flush_valid", out_valid, 0);
        chk("rnd_flush_ready", out_ready, 1);
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_pipe.md
REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, payload width in bits.
REQ-002 SHALL have parameter RSTN_VALUE, default 0, value loaded into every data register on reset.
REQ-003 SHALL have parameter DEPTH, default 1, number of pipeline stages; DEPTH < 1 SHALL be an elaboration error.
REQ-004 SHALL have port i_clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_flush  input  1  synchronous flush of all held words.
REQ-007 SHALL have port i_valid  input  1  upstream word present.
REQ-008 SHALL have port o_ready  output  1  pipe can accept a word.
REQ-009 SHALL have port i_data  input  DATA_WIDTH  upstream payload.
REQ-010 SHALL have port o_valid  output  1  downstream word present.
REQ-011 SHALL have port i_ready  input  1  downstream accepts a word.
REQ-012 SHALL have port o_data  output  DATA_WIDTH  downstream payload.
REQ-013 SHALL have port o_count  output  $clog2(2*DEPTH+1)  words currently held.

Function
REQ-014 Input fire = i_valid & o_ready; output fire = o_valid & i_ready; a word transfers only on fire at a rising edge.
REQ-015 Pipe SHALL be a chain of DEPTH skid stages; stage k output feeds stage k+1 input; capacity 2*DEPTH words.
REQ-016 Each stage SHALL hold a main register and a skid register; stage states EMPTY, BUSY (main only), FULL (main + skid).
REQ-017 EMPTY: in-fire -> load main, go BUSY; else stay.
REQ-018 BUSY: in-fire & out-fire -> main <= in, stay BUSY; in-fire only -> skid <= in, go FULL; out-fire only -> go EMPTY.
REQ-019 FULL: out-fire -> main <= skid, go BUSY; no in-fire possible in FULL.
REQ-020 Stage upstream ready SHALL equal (state != FULL), taken directly from a register, with no combinational path from downstream ready.
REQ-021 Stage valid SHALL equal (state != EMPTY); stage data SHALL be the main register.
REQ-022 Minimum latency: a word accepted at edge n SHALL appear on o_data with o_valid=1 after edge n+DEPTH-1, i.e. DEPTH cycles, when downstream never stalls.
REQ-023 Sustained throughput SHALL be one word per cycle with i_valid=i_ready=1.
REQ-024 Order SHALL be preserved; no word duplicated or lost except by flush or reset.
REQ-025 o_data SHALL hold steady while o_valid=1 and i_ready=0.
REQ-026 o_count SHALL increment on in-fire only, decrement on out-fire only, hold on both or neither; it never exceeds 2*DEPTH.
REQ-027 i_flush=1 at an edge SHALL set every stage EMPTY and o_count to 0, overriding any simultaneous fire; a word in-fired that cycle is discarded; data registers keep their contents.
REQ-028 After flush, o_ready SHALL be 1 and o_valid 0 in the following cycle.

Reset
REQ-029 i_rst_n=0 SHALL, without waiting for a clock edge, force every stage EMPTY, every data register to RSTN_VALUE, o_count to 0.
REQ-030 During and after reset: o_valid=0, o_data=RSTN_VALUE, o_ready=1, o_count=0.
REQ-031 Reset asserted mid-transfer SHALL discard all held words; operation resumes at the first rising edge after release.

Structure
REQ-032 Shared package reg_pkg SHALL hold the stage-state enum typedef (EMPTY/BUSY/FULL) and the count-width function.
REQ-033 One sub-module reg_skid SHALL implement a single stage (DATA_WIDTH, RSTN_VALUE), instantiated DEPTH times via generate; occupancy counter and flush fan-out SHALL live in reg_pipe.

Verification (DATA_WIDTH=8, DEPTH=2, RSTN_VALUE=8'hA5)
REQ-034 Hold i_rst_n=0 -> o_valid=0, o_data=8'hA5, o_ready=1, o_count=0 immediately.
REQ-035 i_valid=i_ready=1, data 1..10 on consecutive cycles -> o_data 1..10 on consecutive cycles, first 2 cycles after first accept, o_count steady at 2.
REQ-036 i_ready=0, offer 1..5 -> 4 accepted, o_ready=0, o_count=4, word 5 held upstream; then i_ready=1 -> output 1..5 in order, none lost.
REQ-037 o_count=3 with i_flush=1 and simultaneous in-fire of 8'h77 -> next cycle o_valid=0, o_count=0, o_ready=1; 8'h77 never output.
REQ-038 i_rst_n dropped between edges mid-stream -> outputs at reset values before next edge; stream restarted afterwards delivers in order.
REQ-039 1000 cycles random i_valid/i_ready/rare i_flush -> scoreboard matches order and o_count every cycle.
